// File: rtl/warp_lsu_if.sv
// Shared types and the data-memory request/response bus for the warp load/store unit.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_lsu_pkg;
    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;
endpackage

interface warp_lsu_if #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) ();
    logic                  mem_req_valid;
    logic                  mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    // LSU side drives requests and consumes responses
    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Memory side accepts requests and returns load data
    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/warp_lsu.sv
// Per-warp load/store unit: serializes active lanes onto one memory port,
// one outstanding load at a time, and collects per-lane load results.

module warp_lsu
    import warp_lsu_pkg::*;
#(
    parameter int unsigned THREADS_PER_WARP = 32,
    parameter int unsigned DATA_WIDTH       = `DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [THREADS_PER_WARP-1:0] thread_enable,
    input  warp_state_t                 warp_state,
    input  logic                        decoded_mem_read_enable,
    input  logic                        decoded_mem_write_enable,
    input  data_t                       rs1 [THREADS_PER_WARP],
    input  data_t                       rs2 [THREADS_PER_WARP],
    warp_lsu_if.master                  mem,
    output data_t                       lsu_out [THREADS_PER_WARP],
    output logic                        lsu_done
);

    localparam int unsigned LANE_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_t;

    lsu_state_t                  state_q, state_d;
    logic [THREADS_PER_WARP-1:0] pending_q, pending_d;
    logic                        is_load_q, is_load_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic                        req_valid_q, req_valid_d;
    logic                        req_write_q, req_write_d;
    logic [DATA_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]       req_data_q, req_data_d;
    data_t                       lsu_out_q [THREADS_PER_WARP];
    data_t                       lsu_out_d [THREADS_PER_WARP];
    logic                        done_q, done_d;

    logic [THREADS_PER_WARP-1:0] cleared;
    logic [THREADS_PER_WARP-1:0] issue_mask;
    logic                        issue_load;
    logic                        do_issue;
    logic [LANE_W-1:0]           sel;

    // Priority encoder: index of the lowest set bit (0 when the mask is empty)
    function automatic logic [LANE_W-1:0] lowest_lane(input logic [THREADS_PER_WARP-1:0] m);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = int'(THREADS_PER_WARP) - 1; i >= 0; i--) begin
            if (m[i]) idx = LANE_W'(i);
        end
        return idx;
    endfunction

    // Next-state and next-output computation for the operation sequencer
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        is_load_d   = is_load_q;
        lane_d      = lane_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        lsu_out_d   = lsu_out_q;
        done_d      = done_q;

        cleared          = pending_q;
        cleared[lane_q]  = 1'b0;
        issue_mask       = '0;
        issue_load       = is_load_q;
        do_issue         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable && warp_state == WARP_WAIT &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    pending_d  = thread_enable;
                    is_load_d  = decoded_mem_read_enable;
                    issue_load = decoded_mem_read_enable;
                    issue_mask = thread_enable;
                    do_issue   = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_valid_q) begin
                    // A presented request is held until accepted, regardless of enable
                    if (mem.mem_req_ready) begin
                        pending_d   = cleared;
                        req_valid_d = 1'b0;
                        if (is_load_q) begin
                            state_d = ST_WAIT_RESP;
                        end else if (cleared == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (enable) begin
                            issue_mask = cleared;
                            do_issue   = 1'b1;
                        end
                    end
                end else if (enable) begin
                    if (pending_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        issue_mask = pending_q;
                        do_issue   = 1'b1;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (mem.mem_resp_valid) begin
                    lsu_out_d[lane_q] = data_t'(mem.mem_resp_data);
                    if (pending_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (enable && warp_state == WARP_UPDATE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Present the lowest pending lane; operands are read live from the register file
        sel = lowest_lane(issue_mask);
        if (do_issue && issue_mask != '0) begin
            lane_d      = sel;
            req_valid_d = 1'b1;
            req_write_d = !issue_load;
            req_addr_d  = DATA_WIDTH'(rs1[sel]);
            req_data_d  = issue_load ? '0 : DATA_WIDTH'(rs2[sel]);
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            is_load_q   <= 1'b0;
            lane_q      <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            lsu_out_q   <= '{default: '0};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            is_load_q   <= is_load_d;
            lane_q      <= lane_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            lsu_out_q   <= lsu_out_d;
            done_q      <= done_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_write = req_write_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_data  = req_data_q;
    assign lsu_out           = lsu_out_q;
    assign lsu_done          = done_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Bench for warp_lsu: behavioural memory, request scoreboard, scenario tasks.

`timescale 1ns/1ps

module tb_warp_lsu;
    import warp_lsu_pkg::*;

    localparam int unsigned T = 4;

    typedef struct {
        logic  wr;
        data_t addr;
        data_t data;
        int    cyc;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [T-1:0]  thread_enable;
    warp_state_t   warp_state;
    logic          rd_en;
    logic          wr_en;
    data_t         rs1 [T];
    data_t         rs2 [T];
    data_t         lsu_out [T];
    logic          lsu_done;

    warp_lsu_if #(.DATA_WIDTH(DATA_WIDTH)) mem_if ();

    warp_lsu #(.THREADS_PER_WARP(T), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .thread_enable            (thread_enable),
        .warp_state               (warp_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .mem                      (mem_if),
        .lsu_out                  (lsu_out),
        .lsu_done                 (lsu_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Written by the memory model only
    req_t acc_q[$];
    int   valid_seen = 0, write_seen = 0, unstable_cnt = 0, resp_fired = 0;
    // Written by the tasks only
    req_t exp_q[$];
    int   acc_rd = 0;
    int   resp_lat = 2;
    int   stall_len = 0;
    int   stall_arm = 0;

    // Memory model: optional stall on the first request after arming, fixed load latency
    initial begin
        int    stall_seen, stall_left, resp_cnt;
        data_t resp_data;
        logic  prev_valid, prev_ready, prev_wr, rdy;
        data_t prev_addr, prev_data;
        stall_seen = 0; stall_left = 0; resp_cnt = 0; resp_data = '0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_wr = 1'b0; prev_addr = '0; prev_data = '0;
        mem_if.mem_req_ready  = 1'b1;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_if.mem_resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_if.mem_resp_valid = 1'b1;
                    mem_if.mem_resp_data  = resp_data;
                    resp_fired++;
                end
            end
            if (prev_valid && !prev_ready &&
                (mem_if.mem_req_valid !== 1'b1 || mem_if.mem_req_write !== prev_wr ||
                 mem_if.mem_req_addr !== prev_addr || mem_if.mem_req_data !== prev_data))
                unstable_cnt++;
            rdy = 1'b1;
            if (mem_if.mem_req_valid === 1'b1) begin
                if (stall_arm != stall_seen) begin
                    stall_seen = stall_arm;
                    stall_left = stall_len;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                valid_seen++;
                if (mem_if.mem_req_write === 1'b1) write_seen++;
            end
            mem_if.mem_req_ready = rdy;
            if (mem_if.mem_req_valid === 1'b1 && rdy) begin
                acc_q.push_back('{mem_if.mem_req_write, mem_if.mem_req_addr, mem_if.mem_req_data, cyc});
                if (mem_if.mem_req_write !== 1'b1) begin
                    resp_cnt  = resp_lat;
                    resp_data = mem_if.mem_req_addr + data_t'(32'h100);
                end
            end
            prev_valid = mem_if.mem_req_valid;
            prev_ready = rdy;
            prev_wr    = mem_if.mem_req_write;
            prev_addr  = mem_if.mem_req_addr;
            prev_data  = mem_if.mem_req_data;
        end
    end

    // Present a WARP_WAIT start cycle; s is the cycle number of that start cycle
    task automatic start_op(input logic r, input logic w, input logic [T-1:0] m, output int s);
        @(negedge clk);
        warp_state    = WARP_WAIT;
        rd_en         = r;
        wr_en         = w;
        thread_enable = m;
        s             = cyc;
        @(negedge clk);
        warp_state    = WARP_EXECUTE;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc, output bit ok);
        ok = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lsu_done === 1'b1) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        warp_state = WARP_UPDATE;
        @(negedge clk);
        warp_state = WARP_IDLE;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; warp_state = WARP_IDLE;
        rd_en = 1'b0; wr_en = 1'b0; thread_enable = '0;
        for (int i = 0; i < int'(T); i++) begin rs1[i] = '0; rs2[i] = '0; end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_if.mem_req_valid); end
        checks++; if (mem_if.mem_req_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", mem_if.mem_req_write); end
        checks++; if (mem_if.mem_req_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_if.mem_req_addr); end
        checks++; if (mem_if.mem_req_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_if.mem_req_data); end
        checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", lsu_done); end
        for (int i = 0; i < int'(T); i++) begin
            checks++; if (lsu_out[i] !== '0) begin errors++; $display("FAIL reset_lsu_out[%0d]: got %h want 0", i, lsu_out[i]); end
        end
    endtask

    task automatic test_load_full();
        int s, dc; bit ok; req_t e, a;
        for (int i = 0; i < int'(T); i++) begin
            rs1[i] = data_t'(32'h10 + 4 * i);
            rs2[i] = data_t'(32'hDEAD_0000 + i);
        end
        resp_lat = 2;
        start_op(1'b1, 1'b0, 4'b1111, s);
        for (int i = 0; i < int'(T); i++) exp_q.push_back('{1'b0, rs1[i], '0, s + 1 + i * 4});
        wait_done(200, dc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_done_timeout: lsu_done never rose"); end
        checks++; if (dc != s + 1 + (int'(T) - 1) * 4 + 3) begin errors++; $display("FAIL load_done_cycle: got %0d want %0d", dc - s, 1 + (int'(T) - 1) * 4 + 3); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (acc_rd >= acc_q.size()) begin
                errors++; $display("FAIL load_req: missing request for addr %h", e.addr);
            end else begin
                a = acc_q[acc_rd]; acc_rd++;
                if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data || a.cyc != e.cyc) begin
                    errors++;
                    $display("FAIL load_req: got wr=%0b addr=%h data=%h cyc=%0d want wr=%0b addr=%h data=%h cyc=%0d",
                             a.wr, a.addr, a.data, a.cyc - s, e.wr, e.addr, e.data, e.cyc - s);
                end
            end
        end
        checks++; if (acc_rd != acc_q.size()) begin errors++; $display("FAIL load_extra_req: got %0d accepted want %0d", acc_q.size(), acc_rd); acc_rd = acc_q.size(); end
        for (int i = 0; i < int'(T); i++) begin
            checks++; if (lsu_out[i] !== data_t'(32'h110 + 4 * i)) begin errors++; $display("FAIL load_lsu_out[%0d]: got %h want %h", i, lsu_out[i], 32'h110 + 4 * i); end
        end
        repeat (2) @(negedge clk);
        checks++; if (lsu_done !== 1'b1) begin errors++; $display("FAIL load_done_hold: got %b want 1", lsu_done); end
        finish_op();
        checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL load_done_clear: got %b want 0", lsu_done); end
    endtask

    task automatic test_store_backpressure();
        int s, dc, v0, w0, u0; bit ok; req_t e, a;
        data_t snap [T];
        snap = lsu_out;
        for (int i = 0; i < int'(T); i++) rs1[i] = data_t'(32'h40 + 4 * i);
        rs2[0] = data_t'(32'h11); rs2[1] = data_t'(32'hAA);
        rs2[2] = data_t'(32'h33); rs2[3] = data_t'(32'hBB);
        stall_len = 3;
        stall_arm++;
        v0 = valid_seen; w0 = write_seen; u0 = unstable_cnt;
        start_op(1'b0, 1'b1, 4'b1010, s);
        exp_q.push_back('{1'b1, rs1[1], rs2[1], s + 4});
        exp_q.push_back('{1'b1, rs1[3], rs2[3], s + 5});
        wait_done(200, dc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL store_done_timeout: lsu_done never rose"); end
        checks++; if (dc != s + 6) begin errors++; $display("FAIL store_done_cycle: got %0d want 6", dc - s); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (acc_rd >= acc_q.size()) begin
                errors++; $display("FAIL store_req: missing request for addr %h", e.addr);
            end else begin
                a = acc_q[acc_rd]; acc_rd++;
                if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data || a.cyc != e.cyc) begin
                    errors++;
                    $display("FAIL store_req: got wr=%0b addr=%h data=%h cyc=%0d want wr=%0b addr=%h data=%h cyc=%0d",
                             a.wr, a.addr, a.data, a.cyc - s, e.wr, e.addr, e.data, e.cyc - s);
                end
            end
        end
        checks++; if (acc_rd != acc_q.size()) begin errors++; $display("FAIL store_extra_req: got %0d accepted want %0d", acc_q.size(), acc_rd); acc_rd = acc_q.size(); end
        checks++; if (valid_seen - v0 != 5) begin errors++; $display("FAIL store_valid_cycles: got %0d want 5", valid_seen - v0); end
        checks++; if (write_seen - w0 != 5) begin errors++; $display("FAIL store_write_cycles: got %0d want 5", write_seen - w0); end
        checks++; if (unstable_cnt != u0) begin errors++; $display("FAIL store_held_stable: got %0d changes want 0", unstable_cnt - u0); end
        for (int i = 0; i < int'(T); i++) begin
            checks++; if (lsu_out[i] !== snap[i]) begin errors++; $display("FAIL store_lsu_out[%0d]: got %h want %h", i, lsu_out[i], snap[i]); end
        end
        finish_op();
    endtask

    task automatic test_empty_mask();
        int s, dc, v0; bit ok;
        v0 = valid_seen;
        start_op(1'b1, 1'b0, '0, s);
        wait_done(50, dc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL empty_done_timeout: lsu_done never rose"); end
        checks++; if (dc != s + 2) begin errors++; $display("FAIL empty_done_cycle: got %0d want 2", dc - s); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL empty_no_req: got %0d valid cycles want 0", valid_seen - v0); end
        finish_op();
    endtask

    task automatic test_read_write_both();
        int s, dc, w0; bit ok; req_t e, a;
        data_t snap [T];
        snap = lsu_out;
        for (int i = 0; i < int'(T); i++) rs1[i] = data_t'(32'h80 + 4 * i);
        resp_lat = 1;
        w0 = write_seen;
        start_op(1'b1, 1'b1, 4'b0101, s);
        exp_q.push_back('{1'b0, rs1[0], '0, s + 1});
        exp_q.push_back('{1'b0, rs1[2], '0, s + 4});
        wait_done(200, dc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rw_done_timeout: lsu_done never rose"); end
        checks++; if (dc != s + 6) begin errors++; $display("FAIL rw_done_cycle: got %0d want 6", dc - s); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (acc_rd >= acc_q.size()) begin
                errors++; $display("FAIL rw_req: missing request for addr %h", e.addr);
            end else begin
                a = acc_q[acc_rd]; acc_rd++;
                if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data || a.cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rw_req: got wr=%0b addr=%h data=%h cyc=%0d want wr=%0b addr=%h data=%h cyc=%0d",
                             a.wr, a.addr, a.data, a.cyc - s, e.wr, e.addr, e.data, e.cyc - s);
                end
            end
        end
        checks++; if (acc_rd != acc_q.size()) begin errors++; $display("FAIL rw_extra_req: got %0d accepted want %0d", acc_q.size(), acc_rd); acc_rd = acc_q.size(); end
        checks++; if (write_seen != w0) begin errors++; $display("FAIL rw_no_write: got %0d write cycles want 0", write_seen - w0); end
        checks++; if (lsu_out[0] !== data_t'(32'h180)) begin errors++; $display("FAIL rw_lsu_out[0]: got %h want 180", lsu_out[0]); end
        checks++; if (lsu_out[2] !== data_t'(32'h188)) begin errors++; $display("FAIL rw_lsu_out[2]: got %h want 188", lsu_out[2]); end
        checks++; if (lsu_out[1] !== snap[1]) begin errors++; $display("FAIL rw_masked[1]: got %h want %h", lsu_out[1], snap[1]); end
        checks++; if (lsu_out[3] !== snap[3]) begin errors++; $display("FAIL rw_masked[3]: got %h want %h", lsu_out[3], snap[3]); end
        finish_op();
    endtask

    task automatic test_reset_mid_load();
        int s, s2, dc, v0, r0, n0; bit ok;
        rs1[0] = data_t'(32'h10);
        resp_lat = 4;
        r0 = resp_fired;
        n0 = acc_q.size();
        start_op(1'b1, 1'b0, 4'b0001, s);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        v0 = valid_seen;
        while (cyc < s + 8) @(negedge clk);
        checks++; if (acc_q.size() != n0 + 1) begin errors++; $display("FAIL rst_one_req: got %0d accepted want 1", acc_q.size() - n0); end
        acc_rd = acc_q.size();
        checks++; if (resp_fired != r0 + 1) begin errors++; $display("FAIL rst_late_resp_sent: got %0d want 1", resp_fired - r0); end
        for (int i = 0; i < int'(T); i++) begin
            checks++; if (lsu_out[i] !== '0) begin errors++; $display("FAIL rst_lsu_out[%0d]: got %h want 0", i, lsu_out[i]); end
        end
        checks++; if (lsu_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", lsu_done); end
        checks++; if (valid_seen != v0) begin errors++; $display("FAIL rst_no_req: got %0d valid cycles want 0", valid_seen - v0); end
        start_op(1'b1, 1'b0, '0, s2);
        wait_done(50, dc, ok);
        checks++; if (!ok || dc != s2 + 2) begin errors++; $display("FAIL rst_idle_restart: got done at %0d want 2", dc - s2); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_store_backpressure();
        test_empty_mask();
        test_read_write_both();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
